// File: rtl/ysyx_22041412_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: func3 encodings,
// the "no access" func3 marker, FSM state type and an alignment helper.
package ysyx_22041412_lsu_pkg;

    // Load func3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    // Store func3 encodings
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    // Tells the SRAM that no sized access is in flight (its output reads as 0)
    localparam logic [2:0] FUNC3_NONE = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } lsu_state_e;

    // Low address bits that must be zero for an access of 1<<size bytes
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_22041412_lsu_chk.sv
// Combinational legality check for a memory request: rejects unknown func3
// encodings and accesses not aligned to their own size. Non-memory ops are
// never illegal. Callers resolve load/store conflicts before this point.
module ysyx_22041412_lsu_chk
    import ysyx_22041412_lsu_pkg::*;
(
    input  logic       is_load_i,
    input  logic       is_store_i,
    input  logic [2:0] func3_i,
    input  logic [2:0] addr_lo_i,
    output logic       illegal_o
);

    logic f3_ok;
    logic misaligned;

    // Decode func3 legality per access kind and test alignment
    always_comb begin
        f3_ok = 1'b0;
        if (is_load_i) begin
            case (func3_i)
                LB, LH, LW, LD, LBU, LHU, LWU: f3_ok = 1'b1;
                default:                       f3_ok = 1'b0;
            endcase
        end else if (is_store_i) begin
            case (func3_i)
                SB, SH, SW, SD: f3_ok = 1'b1;
                default:        f3_ok = 1'b0;
            endcase
        end
        misaligned = |(addr_lo_i & align_mask(func3_i[1:0]));
        illegal_o  = (is_load_i | is_store_i) & (~f3_ok | misaligned);
    end

endmodule

// File: rtl/ysyx_22041412_lsu.sv
// MEM stage: accepts one op from EX, drives the data SRAM for a single
// ISSUE cycle, waits out the read latency, captures load data and holds the
// result for WB until it is taken. SRAM enables are decoded from the state
// register so an asynchronous reset drops them immediately.
module ysyx_22041412_lsu
    import ysyx_22041412_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // EX side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [2:0]            in_func3,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic [DATA_WIDTH-1:0] in_alu_res,
    input  logic [4:0]            in_rd,
    // SRAM side
    output logic [ADDR_WIDTH-1:0] mem_addr_r,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_addr_w,
    output logic                  mem_wead_en,
    output logic [DATA_WIDTH-1:0] mem_data_w,
    output logic [2:0]            mem_func3,
    input  logic [DATA_WIDTH-1:0] mem_data_r,
    // WB side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_rd,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_exc
);

    // Counter preload for the WAIT state (only meaningful when MEM_LAT > 1)
    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    lsu_state_e            state_q, state_d;
    logic                  ld_q, ld_d;
    logic                  st_q, st_d;
    logic [2:0]            func3_q, func3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [4:0]            rd_q, rd_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  exc_q, exc_d;

    // A request flagged as both load and store is handled as a load
    logic in_st_eff;
    logic illegal;

    assign in_st_eff = in_is_store & ~in_is_load;

    ysyx_22041412_lsu_chk u_chk (
        .is_load_i  (in_is_load),
        .is_store_i (in_st_eff),
        .func3_i    (in_func3),
        .addr_lo_i  (in_addr[2:0]),
        .illegal_o  (illegal)
    );

    // Next-state and datapath register update
    always_comb begin
        state_d  = state_q;
        ld_d     = ld_q;
        st_d     = st_q;
        func3_d  = func3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ld_d     = in_is_load;
                    st_d     = in_st_eff;
                    func3_d  = in_func3;
                    addr_d   = in_addr;
                    wdata_d  = in_wdata;
                    rd_d     = in_rd;
                    cnt_d    = 3'd0;
                    result_d = '0;
                    exc_d    = 1'b0;
                    if (!in_is_load && !in_is_store) begin
                        result_d = in_alu_res;
                        state_d  = S_RESP;
                    end else if (illegal) begin
                        exc_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (st_q) begin
                    state_d = S_RESP;
                end else if (MEM_LAT == 1) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_CAPTURE: begin
                result_d = mem_data_r;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and request registers, async active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ld_q     <= 1'b0;
            st_q     <= 1'b0;
            func3_q  <= FUNC3_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 5'd0;
            cnt_q    <= 3'd0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_q     <= ld_d;
            st_q     <= st_d;
            func3_q  <= func3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    // Outputs decoded from state; st_q already excludes loads so the two
    // enables are mutually exclusive
    always_comb begin
        in_ready    = (state_q == S_IDLE);
        mem_read_en = (state_q == S_ISSUE) & ld_q;
        mem_wead_en = (state_q == S_ISSUE) & st_q;
        mem_addr_r  = addr_q;
        mem_addr_w  = addr_q;
        mem_data_w  = wdata_q;
        mem_func3   = (state_q == S_ISSUE || state_q == S_WAIT ||
                       state_q == S_CAPTURE) ? func3_q : FUNC3_NONE;
        out_valid   = (state_q == S_RESP);
        out_rd      = rd_q;
        out_result  = result_q;
        out_exc     = exc_q;
    end

endmodule
